// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order requests to a
// variable-latency instruction memory and buffers returned words for IF/ID.
module if_fetch_queue #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_inst,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [63:0] out_pc_plus4,
    output logic [31:0] out_inst,
    input  logic        out_ready
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(2 * QUEUE_DEPTH) + 1;

    logic [63:0]            fetch_pc;
    logic [63:0]            q_pc     [QUEUE_DEPTH];
    logic [31:0]            q_inst   [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_filled;
    logic [PW-1:0]          head_ptr;
    logic [PW-1:0]          tail_ptr;
    logic [PW-1:0]          fill_ptr;
    logic [CW-1:0]          count;
    logic [CW-1:0]          unfilled_cnt;
    logic [DW-1:0]          drop_cnt;

    logic                   req_fire;
    logic                   pop;
    logic                   resp_drop;
    logic                   resp_fill;
    logic                   resp_consumed;
    logic [63:0]            redirect_target;
    logic [DW:0]            drop_sum;
    logic [DW-1:0]          drop_next;

    // Handshakes: a transfer happens on a cycle where valid && ready are both
    // high at the rising edge; valid never depends combinationally on ready.
    // Responses carry no ready and must be accepted whenever they arrive.
    assign imem_req_valid = !rst && !redirect_valid && (count < CW'(QUEUE_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid    = (count != '0) && q_filled[head_ptr];
    assign out_pc       = q_pc[head_ptr];
    assign out_inst     = q_inst[head_ptr];
    assign out_pc_plus4 = out_pc + 64'd4;
    assign pop          = out_valid && out_ready && !redirect_valid;

    // Words for requests made before a redirect are owed to drop_cnt first.
    assign resp_drop       = imem_resp_valid && (drop_cnt != '0);
    assign resp_fill       = imem_resp_valid && (drop_cnt == '0) && (unfilled_cnt != '0);
    assign resp_consumed   = resp_drop || resp_fill;
    assign redirect_target = redirect_pc & ~64'h3;

    always_comb begin
        drop_sum = ({1'b0, drop_cnt} + (DW + 1)'(unfilled_cnt))
                   - (DW + 1)'(resp_consumed);
        drop_next = drop_sum[DW] ? '1 : drop_sum[DW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc     <= RESET_PC;
            head_ptr     <= '0;
            tail_ptr     <= '0;
            fill_ptr     <= '0;
            count        <= '0;
            unfilled_cnt <= '0;
            drop_cnt     <= '0;
        end else if (redirect_valid) begin
            fetch_pc     <= redirect_target;
            head_ptr     <= '0;
            tail_ptr     <= '0;
            fill_ptr     <= '0;
            count        <= '0;
            unfilled_cnt <= '0;
            drop_cnt     <= drop_next;
        end else begin
            if (req_fire) begin
                tail_ptr <= tail_ptr + PW'(1);
                fetch_pc <= fetch_pc + 64'd4;
            end
            if (pop) begin
                head_ptr <= head_ptr + PW'(1);
            end
            if (resp_fill) begin
                fill_ptr <= fill_ptr + PW'(1);
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - DW'(1);
            end
            case ({req_fire, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case ({req_fire, resp_fill})
                2'b10:   unfilled_cnt <= unfilled_cnt + CW'(1);
                2'b01:   unfilled_cnt <= unfilled_cnt - CW'(1);
                default: unfilled_cnt <= unfilled_cnt;
            endcase
        end
    end

    // Entry storage; a redirect only rewinds pointers, stale contents are harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
            end
            q_filled <= '0;
        end else if (!redirect_valid) begin
            if (req_fire) begin
                q_pc[tail_ptr]     <= fetch_pc;
                q_filled[tail_ptr] <= 1'b0;
            end
            if (resp_fill) begin
                q_inst[fill_ptr]   <= imem_resp_inst;
                q_filled[fill_ptr] <= 1'b1;
            end
        end
    end

    resp_has_owner: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (drop_cnt != '0 || unfilled_cnt != '0));

    count_in_range: assert property (@(posedge clk) disable iff (rst)
        (count <= CW'(QUEUE_DEPTH)) && (unfilled_cnt <= count));

endmodule
